alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Control-side initiator for the ALU block. Holds an 8x10-bit register file and accepts one instruction per Run handshake.
//  Drives the ALU's OP, FN, Ain, Gin and Gout in a fixed sequence. Writes the ALU result Q back to the destination register.
//  Sits between the instruction source and the ALU; the ALU samples on negedge CLKb, this block updates on posedge CLKb.
// PARAMETERS
//  W      10  datapath width (OP, Q, DIN, registers)
//  NREG    8  register-file depth; register index width = $clog2(NREG) = 3
// PORTS
//  CLKb   in   1   clock; all state updates on rising edge
//  RSTb   in   1   reset, asynchronous, active-low
//  Run    in   1   start request; sampled only in IDLE
//  INSTR  in  10   [9:6]=FN, [5:3]=rx (dest/A), [2:0]=ry (B)
//  DIN    in   W   immediate for mvi
//  Q      in   W   ALU result
//  OP     out  W   operand bus to ALU
//  FN     out  4   ALU function code
//  Ain    out  1   ALU A-load strobe
//  Gin    out  1   ALU B-load strobe
//  Gout   out  1   ALU evaluate strobe
//  Busy   out  1   high from accept through WB
//  Done   out  1   one-cycle pulse when the instruction retires
//  RDSEL  in   3   debug read select
//  RDATA  out  W   combinational R[RDSEL]
// BEHAVIOUR
//  Reset (RSTb=0, async): state=IDLE; OP, FN, Ain, Gin, Gout, Busy and Done all 0; R0..R7 = 0.
//   The ALU's internal A/B/Q are not reset; Q is ignored until the next EXEC.
//  All outputs are registered; they change only on posedge CLKb. The ALU samples them at the following negedge.
//  States: IDLE, LDA, LDB, EXEC, WB.
//  IDLE: Busy=0. If Run=1 at a posedge, latch INSTR/DIN and decode FN:
//   FN=0000 mv:  R[rx] <= R[ry]; Done=1 next cycle; stay IDLE (1 cycle, no ALU traffic).
//   FN=0001 mvi: R[rx] <= DIN; Done=1 next cycle; stay IDLE.
//   FN=0010..1011 ALU op: go to LDA.
//   FN=1100..1111 reserved: no register write; Done=1 next cycle; stay IDLE.
//  LDA: OP=R[rx], Ain=1, Busy=1 -> LDB.
//  LDB: OP=R[ry], Gin=1 -> EXEC. A is loaded even for inv/flp; the ALU ignores it.
//  EXEC: FN=latched FN, Gout=1, OP=0 -> WB. The ALU updates Q at the mid-cycle negedge.
//  WB: Gout=0. At the posedge ending WB, R[rx] <= Q, Done=1 for the next cycle, and state returns to IDLE.
//  ALU-op latency: Run accepted at edge N; Done high during cycle N+5 (N+1 for mv/mvi/reserved).
//  Strobe rules: Ain, Gin and Gout are mutually exclusive and each high for exactly one cycle. FN holds its value outside EXEC.
//  Run while Busy=1 is ignored, with no queueing; Run may be held high continuously.
//   Back-to-back issue: the next instruction can be accepted in the same cycle Done is high (IDLE).
//  rx==ry is legal: both operands read the same register; the result overwrites it.
//  Arithmetic is the ALU's; results wrap modulo 2^W. This block performs no width change.
//  Register reads in LDA/LDB use current register contents; no bypass is needed because issue is serial.
//  Reset mid-operation: returns to IDLE at once and all strobes drop asynchronously. No write-back; Done is not pulsed.
// TESTING
//  1. Reset, then mvi R1<-5, mvi R2<-3 -> Done pulses; RDATA(R1)=5, RDATA(R2)=3.
//  2. add R1,R2 (INSTR=0010_001_010) -> Ain cycle OP=5, Gin cycle OP=3, Gout with FN=0010; R1=8 at Done (cycle N+5).
//  3. mvi R3<-1023, mvi R4<-1; add R3,R4 -> R3=0 (wrap). Then sub R4,R3 -> R4=1.
//  4. Hold Run=1 across two queued INSTR values -> second accepted only in the Done cycle; strobes never overlap.
//  5. Assert RSTb=0 during LDB of an add -> strobes drop immediately; registers=0; no Done pulse.
//  6. Reserved FN=1111 and mv R5<-R1 -> Done after 1 cycle; Ain/Gin/Gout stay 0; R5=R1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to an external ALU.
// It owns an NREG x W register file and drives the ALU's operand bus and strobes
// in a fixed order: load A, load B, evaluate, then write back.
// Register moves, immediate loads and reserved codes retire in one cycle
// without touching the ALU.
module alu_sequencer #(
  parameter int W    = 10,
  parameter int NREG = 8
) (
  input  logic                    CLKb,
  input  logic                    RSTb,
  input  logic                    Run,
  input  logic [9:0]              INSTR,
  input  logic [W-1:0]            DIN,
  input  logic [W-1:0]            Q,
  output logic [W-1:0]            OP,
  output logic [3:0]              FN,
  output logic                    Ain,
  output logic                    Gin,
  output logic                    Gout,
  output logic                    Busy,
  output logic                    Done,
  input  logic [$clog2(NREG)-1:0] RDSEL,
  output logic [W-1:0]            RDATA
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WB
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     fn_lat_q;
  logic [AW-1:0]  rx_q, ry_q;
  logic [W-1:0]   regs_q [NREG];

  logic [W-1:0]   op_q, op_d;
  logic [3:0]     fn_q, fn_d;
  logic           ain_q, ain_d;
  logic           gin_q, gin_d;
  logic           gout_q, gout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;

  logic [3:0]     in_fn;
  logic [AW-1:0]  in_rx, in_ry;
  logic           in_alu;

  assign in_fn  = INSTR[9:6];
  assign in_rx  = INSTR[5:3];
  assign in_ry  = INSTR[2:0];
  assign in_alu = (in_fn >= 4'd2) && (in_fn <= 4'd11);

  // State register: reset mid-operation abandons the instruction immediately.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: only ALU opcodes leave IDLE; the rest retire in place.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Run && in_alu) state_d = S_LDA;
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: computes the values the registered outputs take in the next state.
  always_comb begin
    op_d    = '0;
    fn_d    = fn_q;
    ain_d   = 1'b0;
    gin_d   = 1'b0;
    gout_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = rx_q;
    wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          if (in_alu) begin
            op_d   = regs_q[in_rx];
            ain_d  = 1'b1;
            busy_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            wr_addr = in_rx;
            if (in_fn == 4'd0) begin
              wr_en   = 1'b1;
              wr_data = regs_q[in_ry];
            end else if (in_fn == 4'd1) begin
              wr_en   = 1'b1;
              wr_data = DIN;
            end
          end
        end
      end
      S_LDA: begin
        op_d   = regs_q[ry_q];
        gin_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_LDB: begin
        fn_d   = fn_lat_q;
        gout_d = 1'b1;
        busy_d = 1'b1;
      end
      S_EXEC: begin
        busy_d = 1'b1;
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_addr = rx_q;
        wr_data = Q;
        done_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Registered outputs so the ALU sees stable values at the following negedge.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      op_q   <= '0;
      fn_q   <= '0;
      ain_q  <= 1'b0;
      gin_q  <= 1'b0;
      gout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      fn_q   <= fn_d;
      ain_q  <= ain_d;
      gin_q  <= gin_d;
      gout_q <= gout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Instruction latch: captured only when an ALU op is accepted.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      fn_lat_q <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
    end else if (state_q == S_IDLE && Run && in_alu) begin
      fn_lat_q <= in_fn;
      rx_q     <= in_rx;
      ry_q     <= in_ry;
    end
  end

  // Register file: single write port shared by mv/mvi and ALU write-back.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign OP    = op_q;
  assign FN    = fn_q;
  assign Ain   = ain_q;
  assign Gin   = gin_q;
  assign Gout  = gout_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign RDATA = regs_q[RDSEL];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a strobe-driven ALU model
// and an architectural register-file model (R[rx] = f(R[rx], R[ry])).
module tb_alu_sequencer;

  logic       CLKb = 1'b0;
  logic       RSTb = 1'b0;
  logic       Run = 1'b0;
  logic [9:0] INSTR = '0;
  logic [9:0] DIN = '0;
  logic [9:0] Q;
  logic [9:0] OP;
  logic [3:0] FN;
  logic       Ain, Gin, Gout, Busy, Done;
  logic [2:0] RDSEL = '0;
  logic [9:0] RDATA;

  int testsRun = 0;
  int testsFailed = 0;

  logic [9:0] mdl [8];
  logic [9:0] aluA, aluB;

  alu_sequencer #(.W(10), .NREG(8)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .Run(Run), .INSTR(INSTR), .DIN(DIN), .Q(Q),
    .OP(OP), .FN(FN), .Ain(Ain), .Gin(Gin), .Gout(Gout), .Busy(Busy),
    .Done(Done), .RDSEL(RDSEL), .RDATA(RDATA)
  );

  always #5 CLKb = ~CLKb;

  // ALU function table used both by the ALU model and the architectural model.
  function automatic logic [9:0] aluRef(input logic [3:0] fn, input logic [9:0] a, input logic [9:0] b);
    logic [9:0] r;
    r = '0;
    case (fn)
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~b;
      4'd8:  for (int i = 0; i < 10; i++) r[i] = b[9-i];
      4'd9:  r = a << 1;
      4'd10: r = a >> 1;
      4'd11: r = b - a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // External ALU: samples the sequencer's strobes at the negedge.
  always @(negedge CLKb) begin
    if (Ain)  aluA <= OP;
    if (Gin)  aluB <= OP;
    if (Gout) Q    <= aluRef(FN, aluA, aluB);
  end

  // Issue one instruction and check strobe timing, operand values and the result.
  task automatic runInstr(input logic [3:0] fn, input logic [2:0] rx, input logic [2:0] ry, input logic [9:0] din);
    logic        isAlu, wr, overlap;
    int          nCyc;
    logic [9:0]  expRes, seenA, seenB;
    logic [3:0]  seenFn;
    logic [15:0] ainM, ginM, goutM, doneM, busyM;
    logic [79:0] gotT, expT;
    isAlu = (fn >= 4'd2) && (fn <= 4'd11);
    nCyc = isAlu ? 5 : 1;
    wr = 1'b1;
    if (fn == 4'd0)      expRes = mdl[ry];
    else if (fn == 4'd1) expRes = din;
    else if (isAlu)      expRes = aluRef(fn, mdl[rx], mdl[ry]);
    else begin
      expRes = '0;
      wr = 1'b0;
    end
    {ainM, ginM, goutM, doneM, busyM} = '0;
    seenA = '0; seenB = '0; seenFn = '0; overlap = 1'b0;
    @(negedge CLKb);
    Run = 1'b1; INSTR = {fn, rx, ry}; DIN = din;
    for (int c = 1; c <= nCyc; c++) begin
      @(negedge CLKb);
      if (c == 1) Run = 1'b0;
      ainM[c[3:0]] = Ain; ginM[c[3:0]] = Gin; goutM[c[3:0]] = Gout;
      doneM[c[3:0]] = Done; busyM[c[3:0]] = Busy;
      if (Ain)  seenA = OP;
      if (Gin)  seenB = OP;
      if (Gout) seenFn = FN;
      if (!$onehot0({Ain, Gin, Gout})) overlap = 1'b1;
    end
    gotT = {ainM, ginM, goutM, doneM, busyM};
    if (isAlu) expT = {16'h0002, 16'h0004, 16'h0008, 16'h0020, 16'h001E};
    else       expT = {16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000};
    testsRun++;
    if (gotT !== expT) begin
      testsFailed++;
      $display("[TB] FAIL timing fn=%0d: got %h, expected %h", fn, gotT, expT);
    end
    testsRun++;
    if (overlap !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL strobe_overlap fn=%0d: got %b, expected 0", fn, overlap);
    end
    if (isAlu) begin
      testsRun++;
      if (seenA !== mdl[rx] || seenB !== mdl[ry] || seenFn !== fn) begin
        testsFailed++;
        $display("[TB] FAIL operands fn=%0d: got A=%0d B=%0d FN=%0d, expected A=%0d B=%0d FN=%0d",
                 fn, seenA, seenB, seenFn, mdl[rx], mdl[ry], fn);
      end
    end
    if (wr) mdl[rx] = expRes;
    RDSEL = rx;
    #1;
    testsRun++;
    if (RDATA !== mdl[rx]) begin
      testsFailed++;
      $display("[TB] FAIL result fn=%0d R%0d: got %0d, expected %0d", fn, rx, RDATA, mdl[rx]);
    end
  endtask

  // Read back every register through the debug port.
  task automatic test_regs_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      RDSEL = 3'(i);
      #1;
      testsRun++;
      if (RDATA !== 10'd0) begin
        testsFailed++;
        $display("[TB] FAIL %s R%0d: got %0d, expected 0", tag, i, RDATA);
      end
    end
  endtask

  task automatic test_reset();
    RSTb = 1'b0;
    repeat (2) @(negedge CLKb);
    RSTb = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    #1;
    testsRun++;
    if ({OP, FN, Ain, Gin, Gout, Busy, Done} !== 19'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {OP, FN, Ain, Gin, Gout, Busy, Done});
    end
    test_regs_zero("reset_regs");
  endtask

  task automatic test_mvi_add();
    runInstr(4'd1, 3'd1, 3'd0, 10'd5);
    runInstr(4'd1, 3'd2, 3'd0, 10'd3);
    runInstr(4'd2, 3'd1, 3'd2, 10'd0);
    RDSEL = 3'd1;
    #1;
    testsRun++;
    if (RDATA !== 10'd8) begin
      testsFailed++;
      $display("[TB] FAIL add_5_3: got %0d, expected 8", RDATA);
    end
  endtask

  task automatic test_wrap();
    runInstr(4'd1, 3'd3, 3'd0, 10'd1023);
    runInstr(4'd1, 3'd4, 3'd0, 10'd1);
    runInstr(4'd2, 3'd3, 3'd4, 10'd0);
    RDSEL = 3'd3;
    #1;
    testsRun++;
    if (RDATA !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL add_wrap: got %0d, expected 0", RDATA);
    end
    runInstr(4'd3, 3'd4, 3'd3, 10'd0);
    RDSEL = 3'd4;
    #1;
    testsRun++;
    if (RDATA !== 10'd1) begin
      testsFailed++;
      $display("[TB] FAIL sub_after_wrap: got %0d, expected 1", RDATA);
    end
  endtask

  task automatic test_reserved_mv();
    runInstr(4'd15, 3'd6, 3'd1, 10'd77);
    runInstr(4'd0, 3'd5, 3'd1, 10'd0);
    runInstr(4'd2, 3'd2, 3'd2, 10'd0);
  endtask

  // Run held high with a second instruction waiting: it must start only from the Done cycle.
  task automatic test_back_to_back();
    logic [15:0] ainM, ginM, goutM, doneM, busyM;
    logic        overlap;
    logic [9:0]  r1, r2;
    {ainM, ginM, goutM, doneM, busyM} = '0;
    overlap = 1'b0;
    r1 = aluRef(4'd2, mdl[1], mdl[2]);
    r2 = aluRef(4'd3, mdl[2], r1);
    @(negedge CLKb);
    Run = 1'b1; INSTR = {4'd2, 3'd1, 3'd2};
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLKb);
      if (c == 1) INSTR = {4'd3, 3'd2, 3'd1};
      if (c == 6) Run = 1'b0;
      ainM[c[3:0]] = Ain; ginM[c[3:0]] = Gin; goutM[c[3:0]] = Gout;
      doneM[c[3:0]] = Done; busyM[c[3:0]] = Busy;
      if (!$onehot0({Ain, Gin, Gout})) overlap = 1'b1;
    end
    testsRun++;
    if ({ainM, ginM, goutM, doneM, busyM} !== {16'h0042, 16'h0084, 16'h0108, 16'h0420, 16'h03DE} || overlap) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_timing: got %h ovl=%b, expected %h ovl=0",
               {ainM, ginM, goutM, doneM, busyM}, overlap,
               {16'h0042, 16'h0084, 16'h0108, 16'h0420, 16'h03DE});
    end
    mdl[1] = r1;
    mdl[2] = r2;
    RDSEL = 3'd1;
    #1;
    testsRun++;
    if (RDATA !== r1) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_r1: got %0d, expected %0d", RDATA, r1);
    end
    RDSEL = 3'd2;
    #1;
    testsRun++;
    if (RDATA !== r2) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_r2: got %0d, expected %0d", RDATA, r2);
    end
  endtask

  task automatic test_random();
    logic [3:0] fn;
    for (int n = 0; n < 30; n++) begin
      fn = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) fn = 4'd1;
      runInstr(fn, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 10'($urandom_range(1023, 0)));
    end
  endtask

  // Reset during LDB: strobes drop at once, registers clear, no Done follows.
  task automatic test_reset_midop();
    logic sawPulse;
    sawPulse = 1'b0;
    @(negedge CLKb);
    Run = 1'b1; INSTR = {4'd2, 3'd1, 3'd2};
    @(negedge CLKb);
    Run = 1'b0;
    @(negedge CLKb);
    testsRun++;
    if (Gin !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midop_in_ldb: got Gin=%b, expected 1", Gin);
    end
    #2 RSTb = 1'b0;
    #1;
    testsRun++;
    if ({OP, Ain, Gin, Gout, Busy, Done} !== 15'd0) begin
      testsFailed++;
      $display("[TB] FAIL midop_async_drop: got %h, expected 0", {OP, Ain, Gin, Gout, Busy, Done});
    end
    @(negedge CLKb);
    RSTb = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    test_regs_zero("midop_regs");
    for (int c = 0; c < 6; c++) begin
      @(negedge CLKb);
      if (Done || Busy || Ain || Gin || Gout) sawPulse = 1'b1;
    end
    testsRun++;
    if (sawPulse !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midop_no_done: got activity=%b, expected 0", sawPulse);
    end
  endtask

  initial begin
    test_reset();
    test_mvi_add();
    test_wrap();
    test_reserved_mv();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
